// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
//
// Instruction-fetch program counter generator. Holds the PC that addresses
// instruction memory and feeds the IF/ID register, and supplies a
// branch-prediction flag that travels with the fetched instruction.
//
// Optional feature macro: FETCH_BTB_EN
//   defined   - a direct-mapped branch target buffer (BTB) with 2-bit
//               saturating counters predicts taken branches at fetch.
//   undefined - no BTB storage; predict_jump_enable_o is tied to 0 and the
//               bpu_update_* inputs are ignored.
//
// Parameters:
//   RESET_PC   PC loaded by reset.
//   BTB_DEPTH  number of BTB entries (power of two, >= 2).
//
// Ports:
//   clk                    sole clock, rising edge
//   rst                    synchronous active-high reset
//   hold_flag_i[1:0]       pipeline control: 2'b00 none, 2'b01 hold_wait,
//                          2'b10 hold_flush (flush does not stall the PC)
//   jump_enable_i          execute-stage redirect request
//   jump_addr_i[31:0]      redirect target (low two bits forced to zero)
//   bpu_update_en_i        BTB training strobe
//   bpu_update_pc_i[31:0]  PC of the resolved branch
//   bpu_update_target_i    resolved target
//   bpu_update_taken_i     resolved direction
//   inst_addr_o[31:0]      registered current PC
//   predict_jump_enable_o  prediction for the instruction at inst_addr_o
// -----------------------------------------------------------------------------
module fetch_pc #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  hold_flag_i,
    input  logic        jump_enable_i,
    input  logic [31:0] jump_addr_i,
    input  logic        bpu_update_en_i,
    input  logic [31:0] bpu_update_pc_i,
    input  logic [31:0] bpu_update_target_i,
    input  logic        bpu_update_taken_i,
    output logic [31:0] inst_addr_o,
    output logic        predict_jump_enable_o
);

    localparam logic [1:0] HOLD_WAIT = 2'b01;

    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic        predict_s;
    logic [31:0] pred_target_s;

    // Redirect targets are always word aligned; the low bits are dropped.
    logic unused_jump_lsb_s;
    assign unused_jump_lsb_s = ^jump_addr_i[1:0];

`ifdef FETCH_BTB_EN
    localparam int IW = $clog2(BTB_DEPTH);
    localparam int TW = 30 - IW;

    // Saturating 2-bit counter step up (stops at 3).
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : (c + 2'b01);
    endfunction

    // Saturating 2-bit counter step down (stops at 0).
    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : (c - 2'b01);
    endfunction

    logic [BTB_DEPTH-1:0] valid_r;
    logic [TW-1:0]        tag_r    [BTB_DEPTH];
    logic [31:0]          target_r [BTB_DEPTH];
    logic [1:0]           ctr_r    [BTB_DEPTH];

    logic [IW-1:0] look_idx_s;
    logic [TW-1:0] look_tag_s;
    logic          look_hit_s;
    logic [IW-1:0] upd_idx_s;
    logic [TW-1:0] upd_tag_s;
    logic          upd_hit_s;

    // Branch PCs are word aligned, so the update PC low bits carry nothing.
    logic unused_upd_lsb_s;
    assign unused_upd_lsb_s = ^bpu_update_pc_i[1:0];

    assign look_idx_s = pc_r[2+IW-1:2];
    assign look_tag_s = pc_r[31:2+IW];
    assign upd_idx_s  = bpu_update_pc_i[2+IW-1:2];
    assign upd_tag_s  = bpu_update_pc_i[31:2+IW];

    // Lookup and update-side hit detection, both from pre-update contents.
    always_comb begin
        look_hit_s    = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);
        upd_hit_s     = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
        predict_s     = look_hit_s && ctr_r[look_idx_s][1];
        pred_target_s = target_r[look_idx_s];
    end

    // BTB training; reset invalidates all entries and drops any pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                ctr_r[i] <= 2'b01;
            end
        end else if (bpu_update_en_i) begin
            if (upd_hit_s) begin
                if (bpu_update_taken_i) begin
                    ctr_r[upd_idx_s]    <= ctr_inc(ctr_r[upd_idx_s]);
                    target_r[upd_idx_s] <= bpu_update_target_i;
                end else begin
                    ctr_r[upd_idx_s]    <= ctr_dec(ctr_r[upd_idx_s]);
                end
            end else if (bpu_update_taken_i) begin
                // Allocate, evicting whatever aliased into this slot.
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= bpu_update_target_i;
                ctr_r[upd_idx_s]    <= 2'b10;
            end
        end
    end
`else
    logic unused_bpu_s;
    assign unused_bpu_s = ^{bpu_update_en_i, bpu_update_pc_i,
                            bpu_update_target_i, bpu_update_taken_i};

    assign predict_s     = 1'b0;
    assign pred_target_s = 32'h0000_0000;
`endif

    // Next-PC selection: redirect > hold > predicted target > sequential.
    always_comb begin
        next_pc_s = pc_r + 32'd4;
        if (jump_enable_i) begin
            next_pc_s = {jump_addr_i[31:2], 2'b00};
        end else if (hold_flag_i == HOLD_WAIT) begin
            next_pc_s = pc_r;
        end else if (predict_s) begin
            next_pc_s = pred_target_s;
        end else begin
            next_pc_s = pc_r + 32'd4;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign inst_addr_o           = pc_r;
    assign predict_jump_enable_o = predict_s;

endmodule
